// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: state enum, default sizes, range check.
// Imported by the interface, the selector and the arbiter top.
package dmem_arb_pkg;

  localparam int AW_D        = 15;
  localparam int DW_D        = 64;
  localparam int LENW_D      = 4;
  localparam int MEM_WORDS_D = 24577;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_e;

  // last_w is base+len, already widened so it cannot wrap
  function automatic logic burst_fits(
    input logic [31:0] last_w,
    input logic [31:0] words
  );
    return last_w < words;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Requester-side bus of dmem_arbiter: packed per-requester fields.
// master = requesters (drive req/we/addr/len/wdata), slave = arbiter.
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = AW_D,
  parameter int DW   = DW_D,
  parameter int LENW = LENW_D
);

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*LENW-1:0] len;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      wready;
  logic [NREQ-1:0]      rvalid;
  logic [DW-1:0]        rdata;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      err;

  modport master (
    output req, we, addr, len, wdata,
    input  gnt, wready, rvalid, rdata, done, err
  );

  modport slave (
    input  req, we, addr, len, wdata,
    output gnt, wready, rvalid, rdata, done, err
  );

endinterface

// File: rtl/dmem_arb_rr_pick.sv
// rr_pick: combinational round-robin selector. Picks the first set
// req strictly after ptr (mod N); outputs one-hot win, index, valid.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          valid
);

  always_comb begin
    int j;
    j       = 0;
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid   = 1'b1;
        win[j]  = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin burst arbiter for the single-port data memory.
// Ports: clk, rst_n, bus (dmem_arb_if.slave), mem_* memory pins.
// Optional: DMEM_ARB_DUMP_EN raises mem_file_enable on last write beat.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int AW        = AW_D,
  parameter int DW        = DW_D,
  parameter int LENW      = LENW_D,
  parameter int MEM_WORDS = MEM_WORDS_D
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arb_if.slave     bus,
  output logic          mem_write_flag,
  output logic [AW-1:0] mem_dir,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic          mem_file_enable
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              we_q, we_d;
  logic [AW-1:0]     base_q, base_d;
  logic [LENW-1:0]   len_q, len_d;
  logic [LENW-1:0]   beat_q, beat_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [NREQ-1:0]   pick_req;
  logic [NREQ-1:0]   win_oh;
  logic [IW-1:0]     win_idx;
  logic              pick_vld;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [LENW-1:0]   w_len;
  logic [AW:0]       w_last;
  logic [NREQ-1:0]   own_oh;
  logic              in_burst;
  logic              busy;
  logic              wr_beat;
  logic              last_beat;

  // While an err pulse is out the rejected requester still holds req;
  // skipping that one IDLE cycle keeps it from being re-picked.
  assign pick_req = (state_q == IDLE && err_q == '0) ? bus.req : '0;

  rr_pick #(.N(NREQ)) u_pick (
    .req     (pick_req),
    .ptr     (rr_ptr_q),
    .win     (win_oh),
    .win_idx (win_idx),
    .valid   (pick_vld)
  );

  assign w_we   = bus.we[win_idx];
  assign w_addr = bus.addr[int'(win_idx)*AW +: AW];
  assign w_len  = bus.len[int'(win_idx)*LENW +: LENW];
  assign w_last = {1'b0, w_addr} + (AW+1)'(w_len);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    base_d   = base_q;
    len_d    = len_q;
    beat_d   = beat_q;
    err_d    = '0;
    rvalid_d = '0;
    rdata_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          rr_ptr_d = win_idx;
          owner_d  = win_idx;
          we_d     = w_we;
          base_d   = w_addr;
          len_d    = w_len;
          beat_d   = '0;
          if (burst_fits(32'(w_last), 32'(MEM_WORDS)))
            state_d = BURST;
          else
            err_d = win_oh;
        end
      end
      BURST: begin
        beat_d = beat_q + LENW'(1);
        if (!we_q) begin
          rvalid_d = own_oh;
          rdata_d  = mem_data_out;
        end
        if (last_beat) begin
          beat_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= IW'(NREQ-1);
      owner_q  <= '0;
      we_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      err_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      base_q   <= base_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign own_oh    = NREQ'(1) << owner_q;
  assign in_burst  = (state_q == BURST);
  assign busy      = (state_q == BURST) || (state_q == DRAIN);
  assign wr_beat   = in_burst && we_q;
  assign last_beat = (beat_q == len_q);

  assign bus.gnt    = busy ? own_oh : '0;
  assign bus.wready = wr_beat ? own_oh : '0;
  assign bus.done   = (state_q == DRAIN) ? own_oh : '0;
  assign bus.err    = err_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

  assign mem_write_flag = wr_beat;
  assign mem_dir        = in_burst ? base_q + AW'(beat_q) : '0;
  assign mem_data_in    = wr_beat ?
                          bus.wdata[int'(owner_q)*DW +: DW] : '0;

`ifdef DMEM_ARB_DUMP_EN
  assign mem_file_enable = wr_beat && last_beat;
`else
  assign mem_file_enable = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter with a transaction-level
// model: job queues, round-robin winner rule and a shadow memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 15;
  localparam int DW   = 64;
  localparam int LENW = 4;
  localparam int MW   = 24577;

  logic          clk;
  logic          rst_n;
  logic          mem_write_flag;
  logic [AW-1:0] mem_dir;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          mem_file_enable;

  dmem_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .LENW(LENW)) bus ();

  dmem_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LENW(LENW), .MEM_WORDS(MW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .mem_write_flag  (mem_write_flag),
    .mem_dir         (mem_dir),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out),
    .mem_file_enable (mem_file_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // physical memory: async read, write on negedge
  logic [63:0] mem [0:MW-1];
  logic [63:0] ref_mem [0:MW-1];
  bit          preload;

  function automatic logic [63:0] init_word(input int k);
    if (k >= 16 && k < 20) return 64'hA0 + 64'(k - 16);
    return {32'hC0DE0000 | 32'(k), ~32'(k)};
  endfunction

  always @(negedge clk) begin
    if (preload) begin
      for (int k = 0; k < MW; k++) mem[k] <= init_word(k);
    end else if (mem_write_flag) begin
      mem[mem_dir] <= mem_data_in;
    end
  end

  assign mem_data_out = mem[mem_dir];

  int total;
  int bad;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // job tables per requester
  bit          j_we   [NREQ][8];
  int          j_addr [NREQ][8];
  int          j_len  [NREQ][8];
  logic [63:0] j_d    [NREQ][8][16];
  int          njobs  [NREQ];
  int          nxt    [NREQ];
  bit          active [NREQ];
  int          last_w;

  task automatic clear_jobs();
    for (int i = 0; i < NREQ; i++) begin
      njobs[i] = 0;
      nxt[i]   = 0;
    end
  endtask

  task automatic add_job(input int i, input bit we,
                         input int a, input int l);
    int n;
    n = njobs[i];
    j_we[i][n]   = we;
    j_addr[i][n] = a;
    j_len[i][n]  = l;
    for (int k = 0; k < 16; k++)
      j_d[i][n][k] = {$urandom, $urandom};
    njobs[i] = n + 1;
  endtask

  function automatic bit oob(input int i);
    return j_addr[i][nxt[i]] + j_len[i][nxt[i]] > MW - 1;
  endfunction

  function automatic int exp_winner();
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (last_w + k) % NREQ;
      if (active[j]) return j;
    end
    return -1;
  endfunction

  task automatic apply_req(input int i);
    int n;
    n = nxt[i];
    if (n < njobs[i]) begin
      active[i]   = 1'b1;
      bus.req[i]  = 1'b1;
      bus.we[i]   = j_we[i][n];
      bus.addr[i*AW +: AW]     = AW'(j_addr[i][n]);
      bus.len[i*LENW +: LENW]  = LENW'(j_len[i][n]);
      bus.wdata[i*DW +: DW]    = j_d[i][n][0];
    end else begin
      active[i]  = 1'b0;
      bus.req[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.len   = '0;
    bus.wdata = '0;
    for (int i = 0; i < NREQ; i++) active[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    last_w = NREQ - 1;
  endtask

  task automatic run_jobs(input int budget);
    int cyc;
    int n;
    int last_wr [NREQ];
    int gcount  [NREQ];
    int bw      [NREQ];
    int br      [NREQ];
    bit reload  [NREQ];
    bit adv     [NREQ];
    bit exp_fe;
    bit all_done;
    logic [NREQ-1:0] g, gprev, wr, rv, dn, er;
    cyc   = 0;
    gprev = '0;
    for (int i = 0; i < NREQ; i++) begin
      last_wr[i] = 0;
      gcount[i]  = 0;
      bw[i]      = 0;
      br[i]      = 0;
      apply_req(i);
    end
    forever begin
      @(negedge clk);
      cyc++;
      g  = bus.gnt;
      wr = bus.wready;
      rv = bus.rvalid;
      dn = bus.done;
      er = bus.err;
      check("gnt_onehot", 64'($countones(g) <= 1), 1);
      check("wready_owner", 64'(wr & ~g), 0);
      check("rvalid_owner", 64'(rv & ~g), 0);
      exp_fe = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        reload[i] = 1'b0;
        adv[i]    = 1'b0;
        n = nxt[i];
        if (g[i] && !gprev[i]) begin
          check("gnt_order", 64'(i), 64'(exp_winner()));
          check("gnt_fits", 64'(oob(i)), 0);
          gcount[i] = 0;
          bw[i]     = 0;
          br[i]     = 0;
        end
        if (g[i]) gcount[i]++;
        if (wr[i]) begin
          check("wr_dir", 64'(mem_dir), 64'(j_addr[i][n] + bw[i]));
          check("wr_data", mem_data_in, j_d[i][n][bw[i]]);
          if (bw[i] == j_len[i][n]) exp_fe = 1'b1;
          ref_mem[j_addr[i][n] + bw[i]] = j_d[i][n][bw[i]];
          bw[i]++;
          last_wr[i] = cyc;
          adv[i] = 1'b1;
        end
        if (rv[i]) begin
          check("rd_data", bus.rdata, ref_mem[j_addr[i][n] + br[i]]);
          br[i]++;
        end
        if (dn[i]) begin
          check("done_gnt", 64'(g[i]), 1);
          check("gnt_cycles", 64'(gcount[i]), 64'(j_len[i][n] + 2));
          if (j_we[i][n]) begin
            check("wr_beats", 64'(bw[i]), 64'(j_len[i][n] + 1));
            check("wr_done_lat", 64'(cyc - last_wr[i]), 1);
          end else begin
            check("rd_beats", 64'(br[i]), 64'(j_len[i][n] + 1));
          end
          nxt[i]++;
          last_w    = i;
          reload[i] = 1'b1;
        end
        if (er[i]) begin
          check("err_order", 64'(i), 64'(exp_winner()));
          check("err_oob", 64'(oob(i)), 1);
          check("err_nognt", 64'(g), 0);
          nxt[i]++;
          last_w    = i;
          reload[i] = 1'b1;
        end
      end
      check("wflag", 64'(mem_write_flag), 64'(|wr));
`ifdef DMEM_ARB_DUMP_EN
      check("file_en", 64'(mem_file_enable), 64'(exp_fe));
`else
      check("file_en", 64'(mem_file_enable), 0);
`endif
      gprev = g;
      all_done = (g == '0);
      for (int i = 0; i < NREQ; i++)
        if (nxt[i] < njobs[i] || reload[i]) all_done = 1'b0;
      if (all_done) break;
      if (cyc >= budget) begin
        check("timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (reload[i])
          apply_req(i);
        else if (adv[i] && bw[i] < 16)
          bus.wdata[i*DW +: DW] = j_d[i][nxt[i]][bw[i]];
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 64'(bus.gnt), 0);
    check({tag, "_rvalid"}, 64'(bus.rvalid), 0);
    check({tag, "_done"}, 64'(bus.done), 0);
    check({tag, "_err"}, 64'(bus.err), 0);
    check({tag, "_wready"}, 64'(bus.wready), 0);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_wflag"}, 64'(mem_write_flag), 0);
    check({tag, "_dir"}, 64'(mem_dir), 0);
  endtask

  initial begin
    bit got_gnt;
    int a;
    total   = 0;
    bad     = 0;
    preload = 1'b1;
    for (int k = 0; k < MW; k++) ref_mem[k] = init_word(k);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    #1;
    preload = 1'b0;
    do_reset();
    check_all_zero("rst");

    // single read of preloaded A0..A3
    clear_jobs();
    add_job(0, 1'b0, 16'h0010, 3);
    run_jobs(100);

    // single write then readback
    clear_jobs();
    add_job(1, 1'b1, 16'h0100, 1);
    j_d[1][0][0] = 64'h1111;
    j_d[1][0][1] = 64'h2222;
    add_job(0, 1'b0, 16'h0100, 1);
    run_jobs(100);

    // contention from reset: 3 bursts each
    do_reset();
    clear_jobs();
    for (int b = 0; b < 3; b++) begin
      add_job(0, 1'(b % 2), 32 + 8 * b, b + 1);
      add_job(1, 1'((b + 1) % 2), 33 + 8 * b, 2);
    end
    run_jobs(200);

    // bounds: reject then accept at the top of memory
    clear_jobs();
    add_job(0, 1'b0, MW - 2, 2);
    add_job(0, 1'b1, MW - 2, 1);
    add_job(1, 1'b0, MW - 2, 1);
    run_jobs(100);

    // dump-length write
    clear_jobs();
    add_job(1, 1'b1, 16'h0300, 2);
    run_jobs(100);

    // reset during beat 2 of a len=7 read
    clear_jobs();
    add_job(0, 1'b0, 16'h0200, 7);
    @(posedge clk);
    #1;
    apply_req(0);
    got_gnt = 1'b0;
    for (int c = 0; c < 20 && !got_gnt; c++) begin
      @(negedge clk);
      if (bus.gnt[0]) got_gnt = 1'b1;
    end
    check("mid_gnt_seen", 64'(got_gnt), 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    bus.req = '0;
    active[0] = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_done", 64'(bus.done), 0);
    rst_n  = 1'b1;
    last_w = NREQ - 1;
    clear_jobs();
    add_job(1, 1'b0, 16'h0200, 2);
    add_job(0, 1'b0, 16'h0208, 1);
    run_jobs(100);

    // random traffic
    for (int r = 0; r < 10; r++) begin
      clear_jobs();
      for (int i = 0; i < NREQ; i++) begin
        for (int b = 0; b < 1 + int'($urandom_range(2)); b++) begin
          if ($urandom_range(3) == 0)
            a = MW - 1 - int'($urandom_range(20));
          else
            a = int'($urandom_range(63));
          add_job(i, 1'($urandom), a, int'($urandom_range(15)));
        end
      end
      run_jobs(400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
